mem_access_unit: RTL

//  M-stage load/store engine fed by the E->M pipeline register (ALU result = address, forwarded rt = store data).

---
 rtl/mem_access_unit_pkg.sv | 42 ++++
 rtl/mem_access_unit_if.sv | 20 ++
 rtl/mem_access_unit_load_align.sv | 51 +++++
 rtl/mem_access_unit.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - mem_pkg: memory op and FSM state types, exception codes, decode helpers
package mem_pkg;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    LW   = 4'd1,
    LH   = 4'd2,
    LHU  = 4'd3,
    LB   = 4'd4,
    LBU  = 4'd5,
    SW   = 4'd6,
    SH   = 4'd7,
    SB   = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  function automatic logic is_load(mem_op_t op);
    return (op == LW) || (op == LH) || (op == LHU) || (op == LB) || (op == LBU);
  endfunction

  function automatic logic is_store(mem_op_t op);
    return (op == SW) || (op == SH) || (op == SB);
  endfunction

  // Word accesses need a 4-byte aligned address, halfword accesses 2-byte aligned
  function automatic logic misaligned(mem_op_t op, logic [1:0] off);
    case (op)
      LW, SW:      return off != 2'b00;
      LH, LHU, SH: return off[0];
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - req/ack data bus between the load/store unit and memory
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// rtl/mem_access_unit_load_align.sv - mem_load_align: load lane select/extend plus store byte enables and lane replication
module mem_load_align
  import mem_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane, extend it for loads, and build lane enables/data for stores
  always_comb begin
    byte_sel  = word[{offset, 3'b000} +: 8];
    half_sel  = offset[1] ? word[31:16] : word[15:0];
    rdata     = word;
    be        = 4'b1111;
    wdata_rep = wdata;
    case (op)
      LB: begin
        rdata = {{24{byte_sel[7]}}, byte_sel};
        be    = 4'b0001 << offset;
      end
      LBU: begin
        rdata = {24'h0, byte_sel};
        be    = 4'b0001 << offset;
      end
      LH: begin
        rdata = {{16{half_sel[15]}}, half_sel};
        be    = offset[1] ? 4'b1100 : 4'b0011;
      end
      LHU: begin
        rdata = {16'h0, half_sel};
        be    = offset[1] ? 4'b1100 : 4'b0011;
      end
      SB: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
      end
      SH: begin
        be        = offset[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - M-stage load/store engine; MEM_TIMEOUT_EN adds a REQ-phase bus timeout
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        flush,
  input  logic        valid_m,
  input  mem_op_t     mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        exc_adel_o,
  output logic        exc_ades_o,
  output logic        bus_err_o,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  state_t      state, state_nxt;
  mem_op_t     op_q;
  logic [1:0]  off_q;
  logic        flushed_q;
  logic [31:0] rdata_q;
  logic        misal, go, timeout, err_q, discard;
  mem_op_t     al_op;
  logic [1:0]  al_off;
  logic [31:0] al_rdata, al_wdata;
  logic [3:0]  al_be;

  assign misal = misaligned(mem_op, addr[1:0]);
  assign go    = valid_m & (is_load(mem_op) | is_store(mem_op)) & ~misal & ~flush;

  assign exc_adel_o = valid_m & (state == IDLE) & is_load(mem_op) & misal;
  assign exc_ades_o = valid_m & (state == IDLE) & is_store(mem_op) & misal;

  assign discard = flushed_q | flush;

  assign al_op  = (state == IDLE) ? mem_op : op_q;
  assign al_off = (state == IDLE) ? addr[1:0] : off_q;

  mem_load_align u_align (
    .op        (al_op),
    .offset    (al_off),
    .word      (bus_rdata),
    .wdata     (wdata),
    .rdata     (al_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] req_cnt;

  assign timeout = (state == REQ) & ~bus_ack & (req_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      req_cnt <= '0;
    end else if ((state == REQ) && !bus_ack && !timeout) begin
      req_cnt <= req_cnt + CW'(1);
    end else begin
      req_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout & (state_nxt == DONE);
    end
  end
`else
  assign timeout = 1'b0;
  assign err_q   = 1'b0;
`endif

  assign bus_err_o     = err_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = (state == DONE) & is_load(op_q) & ~flush & ~err_q;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    case (state)
      IDLE: begin
        stall_o = go;
        if (go) state_nxt = REQ;
      end
      REQ: begin
        stall_o = 1'b1;
        if (bus_ack || timeout) state_nxt = discard ? IDLE : DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      op_q      <= NONE;
      off_q     <= 2'b00;
      flushed_q <= 1'b0;
      rdata_q   <= 32'h0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_be    <= 4'h0;
      bus_wdata <= 32'h0;
    end else begin
      bus_req <= (state_nxt == REQ);
      if ((state == IDLE) && go) begin
        op_q      <= mem_op;
        off_q     <= addr[1:0];
        flushed_q <= 1'b0;
        bus_we    <= is_store(mem_op);
        bus_addr  <= {addr[31:2], 2'b00};
        bus_be    <= al_be;
        bus_wdata <= al_wdata;
      end
      if ((state == REQ) && flush) flushed_q <= 1'b1;
      if ((state == REQ) && bus_ack) rdata_q <= al_rdata;
    end
  end
endmodule
